// File: rtl/roulette_spin_animator.sv
// roulette_spin_animator
// Sweeps a lit pocket index around a roulette wheel and lands it on a
// software-chosen pocket. The sweep runs at a constant fast step period for
// MIN_REVS full revolutions. It then decelerates, adding PERIOD_INC to the
// step period on every step, until the lit pocket equals the latched target.
//
// Ports:
//   clock      - single clock, rising edge
//   reset      - synchronous, active-low
//   target     - requested landing pocket, captured when a start is accepted
//   start      - spin request, level-sampled every cycle while idle
//   led_out    - currently lit pocket (registered), feeds the LED decoder
//   busy       - high while a spin is in progress (registered)
//   done       - one-cycle pulse on the landing edge (registered)
//   bad_target - one-cycle pulse when a start with an illegal target is rejected
module roulette_spin_animator #(
    parameter int NUM_LEDS    = 38,
    parameter int BASE_PERIOD = 2500000,
    parameter int PERIOD_INC  = 250000,
    parameter int MIN_REVS    = 3,
    parameter int PERIOD_W    = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] target,
    input  logic       start,
    output logic [5:0] led_out,
    output logic       busy,
    output logic       done,
    output logic       bad_target
);

    localparam int STEPS_TOTAL = MIN_REVS * NUM_LEDS;
    localparam int STEPS_W     = $clog2(STEPS_TOTAL + 1);

    localparam logic [STEPS_W-1:0]  STEPS_INIT = STEPS_W'(STEPS_TOTAL);
    localparam logic [STEPS_W-1:0]  STEPS_ONE  = STEPS_W'(1);
    localparam logic [PERIOD_W-1:0] BASE_P     = PERIOD_W'(BASE_PERIOD);
    localparam logic [PERIOD_W-1:0] INC_P      = PERIOD_W'(PERIOD_INC);
    localparam logic [PERIOD_W-1:0] ONE_P      = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] ZERO_P     = PERIOD_W'(0);
    localparam logic [5:0]          LAST_LED   = 6'(NUM_LEDS - 1);
    // Seven bits so that NUM_LEDS = 64 is still representable.
    localparam logic [6:0]          NUM_P      = 7'(NUM_LEDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FAST  = 2'd1,
        ST_DECEL = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [5:0]           target_r, target_s;
    logic [PERIOD_W-1:0]  tick_r, tick_s;
    logic [PERIOD_W-1:0]  period_r, period_s;
    logic [STEPS_W-1:0]   steps_r, steps_s;
    logic [5:0]           led_s;
    logic                 busy_s;
    logic                 done_s;
    logic                 bad_s;
    logic                 step_s;
    logic [5:0]           led_inc_s;

    // Period plus PERIOD_INC, clamped to all-ones instead of wrapping to a short period.
    function automatic logic [PERIOD_W-1:0] sat_add(input logic [PERIOD_W-1:0] a);
        logic [PERIOD_W:0] sum;
        sum = {1'b0, a} + {1'b0, INC_P};
        if (sum[PERIOD_W]) begin
            sat_add = {PERIOD_W{1'b1}};
        end else begin
            sat_add = sum[PERIOD_W-1:0];
        end
    endfunction

    assign step_s    = (tick_r == (period_r - ONE_P));
    // The wheel size need not be a power of two, so the wrap is an explicit compare.
    assign led_inc_s = (led_out == LAST_LED) ? 6'd0 : (led_out + 6'd1);

    // Next-state, counter and output logic.
    always_comb begin
        state_s  = state_r;
        target_s = target_r;
        tick_s   = tick_r;
        period_s = period_r;
        steps_s  = steps_r;
        led_s    = led_out;
        busy_s   = busy;
        done_s   = 1'b0;
        bad_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, target} < NUM_P) begin
                        target_s = target;
                        period_s = BASE_P;
                        tick_s   = ZERO_P;
                        steps_s  = STEPS_INIT;
                        state_s  = ST_FAST;
                        busy_s   = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FAST: begin
                if (step_s) begin
                    tick_s  = ZERO_P;
                    led_s   = led_inc_s;
                    steps_s = steps_r - STEPS_ONE;
                    // The last fast step also arms the first decel step period.
                    if (steps_r == STEPS_ONE) begin
                        state_s  = ST_DECEL;
                        period_s = sat_add(BASE_P);
                    end else begin
                        state_s = ST_FAST;
                    end
                end else begin
                    tick_s = tick_r + ONE_P;
                end
            end
            ST_DECEL: begin
                if (step_s) begin
                    tick_s   = ZERO_P;
                    led_s    = led_inc_s;
                    period_s = sat_add(period_r);
                    // Landing is only tested on decel steps, so a target equal
                    // to the entry pocket costs one more full revolution.
                    if (led_inc_s == target_r) begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_DECEL;
                    end
                end else begin
                    tick_s = tick_r + ONE_P;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            target_r   <= 6'd0;
            tick_r     <= ZERO_P;
            period_r   <= ZERO_P;
            steps_r    <= {STEPS_W{1'b0}};
            led_out    <= 6'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bad_target <= 1'b0;
        end else begin
            state_r    <= state_s;
            target_r   <= target_s;
            tick_r     <= tick_s;
            period_r   <= period_s;
            steps_r    <= steps_s;
            led_out    <= led_s;
            busy       <= busy_s;
            done       <= done_s;
            bad_target <= bad_s;
        end
    end

endmodule

// File: doc/roulette_spin_animator.md
# roulette_spin_animator

Animates the roulette wheel between the processor and the LED decoder. The block takes a landing pocket written by software and a start strobe, then sweeps a lit pocket index around the wheel. The sweep runs fast for a fixed number of revolutions, then decelerates until it lands exactly on the requested pocket. Its `led_out` output drives the LED decoder's `led_number` input in place of the raw register value.

## Interface
Parameters:
- `NUM_LEDS`, default 38: pockets on the wheel; legal indices are 0..NUM_LEDS-1, max 64.
- `BASE_PERIOD`, default 2500000: clock cycles per step in the fast phase; must be ≥1.
- `PERIOD_INC`, default 250000: cycles added to the step period on every decel step.
- `MIN_REVS`, default 3: full revolutions in the fast phase; must be ≥1.
- `PERIOD_W`, default 24: width of the period and tick counters.

Ports:
- `clock`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `target`, input, 6: requested landing pocket, sampled when `start` is accepted.
- `start`, input, 1: spin request, level-sampled each cycle.
- `led_out`, output, 6: currently lit pocket, registered.
- `busy`, output, 1: high while a spin is in progress, registered.
- `done`, output, 1: one-cycle pulse on landing, registered.
- `bad_target`, output, 1: one-cycle pulse when a start is rejected, registered.

## Operation
- The state machine has three states: IDLE, FAST and DECEL.
- **Reset** (`reset`=0 at an edge):
  - State goes to IDLE.
  - `led_out`=0, `busy`=0, `done`=0, `bad_target`=0.
  - Tick counter, step counter and period register are cleared.
  - Reset overrides everything, including a spin in progress.
- **IDLE, `start`=1, `target`<NUM_LEDS:**
  - Latch `target`.
  - Load period=BASE_PERIOD, tick=0, steps_left=MIN_REVS*NUM_LEDS.
  - Go to FAST with `busy`=1.
  - The spin starts from the current `led_out`, i.e. the last landed pocket.
- **IDLE, `start`=1, `target`≥NUM_LEDS:** stay in IDLE, pulse `bad_target` for one cycle, `led_out` unchanged.
- **`start` while busy:** ignored. It does not affect the latched target and produces no `bad_target` pulse.
- **Step event:** occurs when tick == period-1.
  - tick returns to 0.
  - `led_out` increments, wrapping from NUM_LEDS-1 to 0.
  - Otherwise tick increments every cycle.
- **FAST:**
  - Each step decrements steps_left.
  - The step that takes steps_left to 0 moves to DECEL and loads period=BASE_PERIOD+PERIOD_INC.
- **DECEL:**
  - Each step adds PERIOD_INC to the period used by the next step.
  - The period saturates at 2^PERIOD_W-1.
  - On the step whose new `led_out` equals the latched target: go to IDLE, `busy`=0, `done`=1 for one cycle.
  - DECEL always takes at least one step. If `led_out` already equals the target on entry, the wheel does a full further revolution of NUM_LEDS steps.
- **Width rules:**
  - steps_left is wide enough to hold MIN_REVS*NUM_LEDS.
  - The `led_out` wrap is a compare against NUM_LEDS-1, not a modulo power of two.

## Timing
- An accepted start at edge E0 gives `busy`=1 after E0. The first step lands at edge E0+BASE_PERIOD.
- The FAST phase occupies exactly MIN_REVS*NUM_LEDS*BASE_PERIOD cycles after E0.
- The k-th DECEL step (k from 1) takes BASE_PERIOD+k*PERIOD_INC cycles, saturated.
- Landing:
  - `led_out`=target, `busy`=0 and `done`=1 all update on the same edge.
  - `done` returns to 0 on the next edge.
  - A new `start` is accepted from the cycle after landing onward.
- `bad_target` is asserted on the edge after the rejected start is sampled and lasts one cycle.
- `led_out` changes only on step edges or reset. It is never glitched between steps.

## Test plan
All scenarios use `NUM_LEDS`=8, `BASE_PERIOD`=2, `PERIOD_INC`=1, `MIN_REVS`=1.

- **Basic spin.** After reset, pulse `start` with `target`=3. Expected:
  - `led_out` steps 1..7,0 every 2 cycles.
  - Then steps to 1, 2, 3 after 3, 4 and 5 cycles.
  - `done` pulses and `busy` falls exactly 28 cycles after acceptance; `led_out`=3 holds afterward.
- **Same-pocket target.** Start from `led_out`=3 with `target`=3. Expected: 8 fast steps, then 8 decel steps with periods 3..10, landing 16+52=68 cycles after acceptance.
- **Out-of-range target.** `start` with `target`=9 in IDLE. Expected: `bad_target` high for exactly 1 cycle, `busy` stays 0, `led_out` unchanged.
- **Start during a spin.** Pulse `start` with `target`=5 mid-spin while spinning to 3. Expected: the wheel still lands on 3 at the original cycle, and no `bad_target` pulse.
- **Reset mid-spin.** Assert `reset` low for 1 cycle during DECEL. Expected: next cycle `led_out`=0, `busy`=0, `done`=0; a subsequent start to 3 behaves exactly as in the basic spin.
- **Saturation.** With `PERIOD_W`=3 and `PERIOD_INC`=3, spin to `target`=7. Expected: the decel period sequence is 5,7,7,… with no wrap to a small value.
